// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: datapath width, divider op encodings
// and the divider state enum.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/muldiv_divider_if.sv
// Start/busy/done handshake between the execute-stage controller (master)
// and the multi-cycle divider (slave).
interface muldiv_divider_if #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
);
    logic            start;
    logic [1:0]      DivOp;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;
    logic            isZero;

    modport master (
        output start, DivOp, A, B,
        input  busy, done, Result, isZero
    );

    modport slave (
        input  start, DivOp, A, B,
        output busy, done, Result, isZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left and conditionally
// subtract the divisor, setting the new quotient bit.
module div_step #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // The borrow out of the (XLEN+1)-bit subtract is the "shifted < divisor" compare.
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: magnitude restoring division with
// sign fix-up, plus a one-cycle path for divide-by-zero and signed overflow.
module muldiv_divider #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    muldiv_divider_if.slave  bus
);
    import riscv_pkg::*;

    localparam int              CW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST     = CW'(XLEN-1);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            accept, is_signed, a_neg, b_neg;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        accept    = bus.start && (state_q == IDLE || state_q == DONE);
        is_signed = ~bus.DivOp[0];
        a_neg     = is_signed & bus.A[XLEN-1];
        b_neg     = is_signed & bus.B[XLEN-1];
        a_abs     = a_neg ? -bus.A : bus.A;
        b_abs     = b_neg ? -bus.B : bus.B;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d   = bus.DivOp;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (bus.B == '0) begin
                        result_d = bus.DivOp[1] ? bus.A : ALL_ONES;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else if (is_signed && bus.A == INT_MIN && bus.B == ALL_ONES) begin
                        result_d = bus.DivOp[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvsr_d  = b_abs;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                case (op_q)
                    DIV_OP_DIV:  result_d = qneg_q ? -quo_q : quo_q;
                    DIV_OP_DIVU: result_d = quo_q;
                    DIV_OP_REM:  result_d = rneg_q ? -rem_q : rem_q;
                    default:     result_d = rem_q;
                endcase
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.isZero = (result_q == '0);
endmodule

// File: tb/tb_muldiv_divider.sv
// Scoreboard bench for muldiv_divider: expected results are queued at issue
// and popped when done rises; latency and busy occupancy are checked per op.
module tb_muldiv_divider;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_divider_if #(.XLEN(XLEN)) bus ();

    muldiv_divider #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [XLEN-1:0] sb[$];

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && !op[0];
        if (b == 32'd0)        r = op[1] ? a : 32'hFFFF_FFFF;
        else if (ovf)          r = op[1] ? 32'd0 : 32'h8000_0000;
        else begin
            case (op)
                DIV_OP_DIV:  r = 32'($signed(a) / $signed(b));
                DIV_OP_DIVU: r = a / b;
                DIV_OP_REM:  r = 32'($signed(a) % $signed(b));
                default:     r = a % b;
            endcase
        end
        return r;
    endfunction

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.DivOp = op;
        bus.A     = a;
        bus.B     = b;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called #1 after the accepting edge; lat counts edges from (and including) it.
    task automatic wait_done(output int lat, output int busy_n, output bit ok);
        lat = 1;
        busy_n = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (bus.busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_vec++; if (bus.Result !== '0)    begin n_err++; $display("FAIL reset_result: got %h expected 0", bus.Result); end
        n_vec++; if (bus.isZero !== 1'b1)  begin n_err++; $display("FAIL reset_iszero: got %b expected 1", bus.isZero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        int lat, bn; bit ok; logic [31:0] exp;
        drive_start(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14);
        wait_done(lat, bn, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL divu_result: got %h expected %h done_seen=%0d", bus.Result, exp, ok); end
        n_vec++; if (lat !== 34)     begin n_err++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        n_vec++; if (bn !== 33)      begin n_err++; $display("FAIL divu_busy_cycles: got %0d expected 33", bn); end
        n_vec++; if (bus.isZero !== 1'b0) begin n_err++; $display("FAIL divu_iszero: got %b expected 0", bus.isZero); end
    endtask

    task automatic test_signed();
        int lat, bn; bit ok; logic [31:0] exp;
        logic [1:0]  ops[4] = '{DIV_OP_DIV, DIV_OP_REM, DIV_OP_REM, DIV_OP_DIV};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] ex[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD};
        for (int i = 0; i < 4; i++) begin
            drive_start(ops[i], as[i], bs[i], ex[i]);
            wait_done(lat, bn, ok);
            exp = sb.pop_front();
            n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL signed_result[%0d]: got %h expected %h done_seen=%0d", i, bus.Result, exp, ok); end
            n_vec++; if (lat !== 34) begin n_err++; $display("FAIL signed_latency[%0d]: got %0d expected 34", i, lat); end
        end
    endtask

    task automatic test_fast_path();
        int lat, bn; bit ok; logic [31:0] exp;
        logic [1:0]  ops[4] = '{DIV_OP_DIV, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            drive_start(ops[i], as[i], bs[i], ex[i]);
            wait_done(lat, bn, ok);
            exp = sb.pop_front();
            n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL fast_result[%0d]: got %h expected %h done_seen=%0d", i, bus.Result, exp, ok); end
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL fast_latency[%0d]: got %0d expected 1", i, lat); end
            n_vec++; if (bn !== 0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL fast_busy[%0d]: got %0d/%b expected 0/0", i, bn, bus.busy); end
            n_vec++; if (bus.isZero !== (exp == 0)) begin n_err++; $display("FAIL fast_iszero[%0d]: got %b expected %b", i, bus.isZero, (exp == 0)); end
        end
    endtask

    task automatic test_ignored_start();
        int lat, dones, first_lat; logic [31:0] exp;
        drive_start(DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100);
        lat = 1; dones = 0; first_lat = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                if (first_lat == 0) first_lat = lat;
            end
            if (lat == 5) begin
                bus.start = 1'b1; bus.DivOp = DIV_OP_DIVU; bus.A = 32'd7; bus.B = 32'd7;
            end
            if (lat == 6) bus.start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        exp = sb.pop_front();
        n_vec++; if (dones !== 1) begin n_err++; $display("FAIL ignored_done_count: got %0d expected 1", dones); end
        n_vec++; if (first_lat !== 34) begin n_err++; $display("FAIL ignored_latency: got %0d expected 34", first_lat); end
        n_vec++; if (bus.Result !== exp) begin n_err++; $display("FAIL ignored_result: got %h expected %h", bus.Result, exp); end
    endtask

    task automatic test_back_to_back();
        int lat, bn; bit ok; logic [31:0] exp;
        drive_start(DIV_OP_DIVU, 32'd50, 32'd5, 32'd10);
        wait_done(lat, bn, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL b2b_first: got %h expected %h done_seen=%0d", bus.Result, exp, ok); end
        bus.start = 1'b1; bus.DivOp = DIV_OP_DIVU; bus.A = 32'd81; bus.B = 32'd9;
        sb.push_back(32'd9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accepted: busy got %b expected 1", bus.busy); end
        n_vec++; if (bus.Result !== 32'd10) begin n_err++; $display("FAIL b2b_hold: got %h expected %h", bus.Result, 32'd10); end
        wait_done(lat, bn, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL b2b_second: got %h expected %h done_seen=%0d", bus.Result, exp, ok); end
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_reset_abort();
        int lat, bn; bit ok; logic [31:0] exp;
        drive_start(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        n_vec++; if (bus.busy !== 1'b0)   begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0)   begin n_err++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        n_vec++; if (bus.Result !== '0)   begin n_err++; $display("FAIL abort_result: got %h expected 0", bus.Result); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3);
        wait_done(lat, bn, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL abort_next: got %h expected %h done_seen=%0d", bus.Result, exp, ok); end
    endtask

    task automatic test_random();
        int lat, bn, want_lat; bit ok; logic [31:0] exp, a, b; logic [1:0] op;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 4 == 1) a = -a;
            if (i == 11) b = 32'd0;
            want_lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
            drive_start(op, a, b, ref_div(op, a, b));
            wait_done(lat, bn, ok);
            exp = sb.pop_front();
            n_vec++; if (!ok || bus.Result !== exp) begin n_err++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.Result, exp); end
            n_vec++; if (lat !== want_lat) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, want_lat); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.DivOp = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_fast_path();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
